// File: rtl/instr_feeder_if.sv
// rtl/instr_feeder_if.sv - shared types and upstream instruction handshake interface for instr_feeder
package instr_feeder_pkg;
    typedef logic [3:0]         opcode_t;
    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    localparam opcode_t ZERO = 4'd0;
    localparam opcode_t ADD  = 4'd1;
    localparam opcode_t SUB  = 4'd2;
    localparam opcode_t MUL  = 4'd3;
    localparam opcode_t DIV  = 4'd4;
    localparam opcode_t MOD  = 4'd5;
    localparam opcode_t SHL  = 4'd6;
    localparam opcode_t SHR  = 4'd7;
    localparam opcode_t POW  = 4'd8;
endpackage

interface instr_feeder_if;
    import instr_feeder_pkg::*;

    logic     in_valid;
    logic     in_ready;
    opcode_t  in_opcode;
    operand_t in_operand_a;
    operand_t in_operand_b;

    // Generator side drives the instruction, feeder answers with ready.
    modport master (
        output in_valid,
        output in_opcode,
        output in_operand_a,
        output in_operand_b,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_opcode,
        input  in_operand_a,
        input  in_operand_b,
        output in_ready
    );
endinterface

// File: rtl/instr_feeder.sv
// rtl/instr_feeder.sv - FIFO-buffered write-side feeder for the instruction register; optional macro INSTR_FEEDER_OPCODE_CHECK_EN
module instr_feeder
    import instr_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int NUM_ENTRIES = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    instr_feeder_if.slave                     in_bus,
    input  logic                              pause,
    input  logic                              ptr_load,
    input  address_t                          ptr_value,
    output logic                              load_en,
    output opcode_t                           opcode,
    output operand_t                          operand_a,
    output operand_t                          operand_b,
    output address_t                          write_pointer,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              wrapped,
    output logic [15:0]                       load_count
`ifdef INSTR_FEEDER_OPCODE_CHECK_EN
    ,
    output logic                              illegal_op
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam address_t      LAST_ADDR  = address_t'(NUM_ENTRIES - 1);

    opcode_t  fifo_op [FIFO_DEPTH];
    operand_t fifo_a  [FIFO_DEPTH];
    operand_t fifo_b  [FIFO_DEPTH];

    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    address_t      next_addr;
    logic          accept;
    logic          push;
    logic          pop;
    logic          legal;

    // Ready depends only on the registered occupancy, never on in_valid.
    assign in_bus.in_ready = (fifo_count != FULL_COUNT);
    assign accept          = in_bus.in_valid && in_bus.in_ready;

`ifdef INSTR_FEEDER_OPCODE_CHECK_EN
    assign legal = (in_bus.in_opcode <= POW);
`else
    assign legal = 1'b1;
`endif

    // Illegal opcodes still complete the handshake but are not stored.
    assign push = accept && legal;
    // Pop decision uses pre-edge occupancy, so a word is never popped on the edge that pushed it.
    assign pop  = (fifo_count != '0) && !pause;

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_idx] <= in_bus.in_opcode;
            fifo_a[wr_idx]  <= in_bus.in_operand_a;
            fifo_b[wr_idx]  <= in_bus.in_operand_b;
        end
    end

    // FIFO indices and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_idx     <= '0;
            rd_idx     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_idx <= wr_idx + 1'b1;
            if (pop)  rd_idx <= rd_idx + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Register-side outputs: strobe, data, address sequencing and statistics.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            load_en       <= 1'b0;
            opcode        <= ZERO;
            operand_a     <= '0;
            operand_b     <= '0;
            write_pointer <= '0;
            next_addr     <= '0;
            wrapped       <= 1'b0;
            load_count    <= '0;
        end else begin
            load_en <= pop;
            if (pop) begin
                opcode        <= fifo_op[rd_idx];
                operand_a     <= fifo_a[rd_idx];
                operand_b     <= fifo_b[rd_idx];
                write_pointer <= next_addr;
                if (load_count != 16'hFFFF) load_count <= load_count + 1'b1;
            end
            // A reload overrides the increment; the current pop still used the old address.
            if (ptr_load) begin
                next_addr <= ptr_value;
            end else if (pop) begin
                if (next_addr == LAST_ADDR) begin
                    next_addr <= '0;
                    wrapped   <= 1'b1;
                end else begin
                    next_addr <= next_addr + 1'b1;
                end
            end
        end
    end

`ifdef INSTR_FEEDER_OPCODE_CHECK_EN
    // Sticky flag for discarded out-of-range opcodes.
    always_ff @(posedge clk) begin
        if (!reset_n)                 illegal_op <= 1'b0;
        else if (accept && !legal)    illegal_op <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_instr_feeder.sv
// tb/tb_instr_feeder.sv - self-checking bench for instr_feeder with a queue-based reference model
module tb_instr_feeder;
    import instr_feeder_pkg::*;

    localparam int DEPTH = 4;
    localparam int NUM   = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pause;
    logic        ptr_load;
    address_t    ptr_value;
    logic        load_en;
    opcode_t     opcode;
    operand_t    operand_a;
    operand_t    operand_b;
    address_t    write_pointer;
    logic [2:0]  fifo_count;
    logic        wrapped;
    logic [15:0] load_count;
`ifdef INSTR_FEEDER_OPCODE_CHECK_EN
    logic        illegal_op;
`endif

    instr_feeder_if bus();

    instr_feeder #(.FIFO_DEPTH(DEPTH), .NUM_ENTRIES(NUM)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_bus        (bus.slave),
        .pause         (pause),
        .ptr_load      (ptr_load),
        .ptr_value     (ptr_value),
        .load_en       (load_en),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .write_pointer (write_pointer),
        .fifo_count    (fifo_count),
        .wrapped       (wrapped),
        .load_count    (load_count)
`ifdef INSTR_FEEDER_OPCODE_CHECK_EN
        ,
        .illegal_op    (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a queue of pending words plus the architectural counters.
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } item_t;

    item_t       q[$];
    item_t       m_item;
    bit          model_on = 1'b0;
    bit          m_do_push;
    bit          m_do_pop;
    logic        m_load_en;
    logic [3:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          m_wp;
    int          m_next;
    logic        m_wrapped;
    int          m_lcount;
    logic        m_illegal;

    always @(posedge clk) begin
        if (!reset_n) begin
            model_on  = 1'b1;
            q.delete();
            m_load_en = 1'b0;
            m_op      = 4'd0;
            m_a       = 32'd0;
            m_b       = 32'd0;
            m_wp      = 0;
            m_next    = 0;
            m_wrapped = 1'b0;
            m_lcount  = 0;
            m_illegal = 1'b0;
        end else if (model_on) begin
            m_do_push = bus.in_valid && (q.size() < DEPTH);
            m_do_pop  = (q.size() > 0) && !pause;
            m_load_en = m_do_pop;
            if (m_do_pop) begin
                m_item = q.pop_front();
                m_op   = m_item.op;
                m_a    = m_item.a;
                m_b    = m_item.b;
                m_wp   = m_next;
                if (m_lcount < 65535) m_lcount++;
            end
            if (ptr_load) begin
                m_next = int'(ptr_value) % NUM;
            end else if (m_do_pop) begin
                m_next = (m_next + 1) % NUM;
                if (m_next == 0) m_wrapped = 1'b1;
            end
            if (m_do_push) begin
`ifdef INSTR_FEEDER_OPCODE_CHECK_EN
                if (bus.in_opcode > 4'd8) m_illegal = 1'b1;
                else q.push_back('{bus.in_opcode, bus.in_operand_a, bus.in_operand_b});
`else
                q.push_back('{bus.in_opcode, bus.in_operand_a, bus.in_operand_b});
`endif
            end
        end
    end

    // Compare process: every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("load_en",       32'(load_en),       32'(m_load_en));
            check("in_ready",      32'(bus.in_ready),  32'(q.size() < DEPTH));
            check("fifo_count",    32'(fifo_count),    32'(q.size()));
            check("write_pointer", 32'(write_pointer), 32'(m_wp));
            check("opcode",        32'(opcode),        32'(m_op));
            check("operand_a",     32'(operand_a),     m_a);
            check("operand_b",     32'(operand_b),     m_b);
            check("wrapped",       32'(wrapped),       32'(m_wrapped));
            check("load_count",    32'(load_count),    32'(m_lcount));
`ifdef INSTR_FEEDER_OPCODE_CHECK_EN
            check("illegal_op",    32'(illegal_op),    32'(m_illegal));
`endif
        end
    end

    // Apply inputs at a falling edge, then advance to the next falling edge.
    task automatic drive(input logic v, input opcode_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic p, input logic pl, input address_t pv);
        bus.in_valid     = v;
        bus.in_opcode    = op;
        bus.in_operand_a = a;
        bus.in_operand_b = b;
        pause            = p;
        ptr_load         = pl;
        ptr_value        = pv;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, ZERO, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
    endtask

    int nloads;

    initial begin
        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_opcode = ZERO; bus.in_operand_a = '0; bus.in_operand_b = '0;
        pause = 1'b0; ptr_load = 1'b0; ptr_value = '0;
        @(negedge clk);

        // Reset state and single ADD latency.
        do_reset();
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_in_ready",   32'(bus.in_ready), 32'd1);
        check("rst_load_en",    32'(load_en), 32'd0);
        check("rst_wp",         32'(write_pointer), 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
        drive(1'b1, ADD, 32'd5, 32'd3, 1'b0, 1'b0, '0);
        check("add_not_yet", 32'(load_en), 32'd0);
        check("add_count1",  32'(fifo_count), 32'd1);
        drive(1'b1, SUB, 32'd9, 32'd1, 1'b0, 1'b0, '0);
        check("add_load_en", 32'(load_en), 32'd1);
        check("add_opcode",  32'(opcode), 32'(ADD));
        check("add_a",       32'(operand_a), 32'd5);
        check("add_b",       32'(operand_b), 32'd3);
        check("add_wp",      32'(write_pointer), 32'd0);
        idle(1);
        check("sub_opcode",  32'(opcode), 32'(SUB));
        check("sub_wp",      32'(write_pointer), 32'd1);
        idle(1);
        check("drained_load_en", 32'(load_en), 32'd0);
        check("two_loads",       32'(load_count), 32'd2);

        // Pause fills the FIFO; release drains it in order.
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, ADD, 32'(100 + i), 32'(i), 1'b1, 1'b0, '0);
        check("full_count",    32'(fifo_count), 32'd4);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("paused_no_load", 32'(load_en), 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, ZERO, '0, '0, 1'b0, 1'b0, '0);
            check("drain_load_en", 32'(load_en), 32'd1);
            check("drain_wp",      32'(write_pointer), 32'(k));
            check("drain_a",       32'(operand_a), 32'(100 + k));
        end
        check("drain_empty", 32'(fifo_count), 32'd0);
        idle(1);
        check("drain_done", 32'(load_en), 32'd0);

        // 33 back-to-back words: pointer wraps after 31.
        do_reset();
        nloads = 0;
        for (int i = 0; i < 36; i++) begin
            drive(i < 33, ADD, 32'(i), 32'(~i), 1'b0, 1'b0, '0);
            if (load_en) begin
                check("wrap_wp",      32'(write_pointer), 32'(nloads % 32));
                check("wrap_a",       32'(operand_a), 32'(nloads));
                check("wrap_wrapped", 32'(wrapped), 32'(nloads >= 31));
                nloads++;
            end
        end
        check("wrap_nloads",     32'(nloads), 32'd33);
        check("wrap_load_count", 32'(load_count), 32'd33);
        check("wrap_sticky",     32'(wrapped), 32'd1);

        // Reset with words buffered drops them.
        for (int i = 0; i < 3; i++) drive(1'b1, MUL, 32'(i), 32'(i), 1'b1, 1'b0, '0);
        check("buffered3", 32'(fifo_count), 32'd3);
        do_reset();
        check("flush_count",   32'(fifo_count), 32'd0);
        check("flush_wp",      32'(write_pointer), 32'd0);
        check("flush_wrapped", 32'(wrapped), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("flush_no_load", 32'(load_en), 32'd0);
        end

        // Pointer reload coinciding with a pop.
        do_reset();
        for (int i = 0; i < 7; i++) drive(1'b1, ADD, 32'(i), 32'd0, 1'b0, 1'b0, '0);
        idle(2);
        check("pre_reload_wp", 32'(write_pointer), 32'd6);
        drive(1'b1, ADD, 32'hA, 32'd0, 1'b0, 1'b0, '0);
        drive(1'b1, SUB, 32'hB, 32'd0, 1'b0, 1'b1, 5'd20);
        check("reload_a",  32'(operand_a), 32'hA);
        check("reload_wp", 32'(write_pointer), 32'd7);
        idle(1);
        check("reload_b",     32'(operand_a), 32'hB);
        check("reload_b_wp",  32'(write_pointer), 32'd20);

`ifdef INSTR_FEEDER_OPCODE_CHECK_EN
        // Out-of-range opcode is swallowed.
        do_reset();
        drive(1'b1, 4'hC, 32'd77, 32'd0, 1'b0, 1'b0, '0);
        check("ill_flag",  32'(illegal_op), 32'd1);
        check("ill_count", 32'(fifo_count), 32'd0);
        drive(1'b1, SUB, 32'd88, 32'd0, 1'b0, 1'b0, '0);
        check("ill_no_load", 32'(load_en), 32'd0);
        idle(1);
        check("ill_sub_load", 32'(load_en), 32'd1);
        check("ill_sub_op",   32'(opcode), 32'(SUB));
        check("ill_sub_wp",   32'(write_pointer), 32'd0);
`endif

        // Randomized traffic, checked cycle by cycle by the compare process.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            drive(1'($urandom_range(0, 3) != 0), opcode_t'($urandom_range(0, 15)), $urandom, $urandom,
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0),
                  address_t'($urandom_range(0, 31)));
        end
        reset_n = 1'b1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
